// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one restoring divide step (one quotient bit per clock) among NREQ requesters.
// Optional DIV_SHARE_ZERO_FAST_EN: zero-divisor requests complete in one cycle and flag rsp_dz.
module div_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      rsp_r,
`ifdef DIV_SHARE_ZERO_FAST_EN
    output logic                  rsp_dz,
`endif
    output logic                  busy
);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_q, id_q, rsp_id_q;
    logic [WIDTH-1:0] b_q, quo_q, rem_q, rsp_q_q, rsp_r_q;
    logic [CNTW-1:0]  cnt_q;
    logic             rsp_valid_q;
    logic             rsp_dz_q;

    logic             found;
    logic [IDW-1:0]   gid, rr_d;
    logic [NREQ-1:0]  grant;
    int unsigned      idx;
    logic [WIDTH-1:0] a_sel, b_sel;

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_d, quo_d;

    // First valid requester at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        idx   = 0;
        grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = IDW'(idx);
            end
        end
        if (found) grant[gid] = 1'b1;
        rr_d  = (32'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
        a_sel = req_a[32'(gid)*WIDTH +: WIDTH];
        b_sel = req_b[32'(gid)*WIDTH +: WIDTH];
    end

    // rst_n gating keeps req_ready at zero while reset is held even with valids pending.
    assign req_ready = (state_q == S_IDLE && rst_n) ? grant : '0;

    // Partial remainder widened by one bit so divisors >= 2^(WIDTH-1) never overflow.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = {1'b0, partial} - {2'b00, b_q};
        borrow  = diff[WIDTH+1];
        rem_d   = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            b_q         <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        id_q  <= gid;
                        b_q   <= b_sel;
                        quo_q <= a_sel;
                        rem_q <= '0;
                        cnt_q <= CNTW'(WIDTH - 1);
                        rr_q  <= rr_d;
`ifdef DIV_SHARE_ZERO_FAST_EN
                        if (b_sel == '0) begin
                            rsp_q_q     <= '1;
                            rsp_r_q     <= a_sel;
                            rsp_id_q    <= gid;
                            rsp_valid_q <= 1'b1;
                            rsp_dz_q    <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
`else
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        rsp_q_q     <= quo_d;
                        rsp_r_q     <= rem_d;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        rsp_dz_q    <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_dz_q    <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign busy      = (state_q != S_IDLE);
`ifdef DIV_SHARE_ZERO_FAST_EN
    assign rsp_dz    = rsp_dz_q;
`else
    logic unused_dz;
    assign unused_dz = rsp_dz_q;
`endif

endmodule
